grid_accumulator: RTL
=====================

GRID_ACCUMULATOR -- requirements
Module: grid_accumulator

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
PRECISION, 32, signed two's-complement width of each real or imaginary value.
SSIZE, 15, number of parallel lanes; each lane owns one grid bank.
BRAM_DEPTH_BITS, 10, address width of each bank (1024 words).
REQ-002 Ports (name  direction  width  meaning), one per line, SHALL be:
clk  in  1  single clock; all state changes on its rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  product beat offered.
in_ready  out  1  beat accepted when in_valid && in_ready at a clk edge.
productr  in  PRECISION*SSIZE  lane k real part at bits [(k+1)*PRECISION-1 : k*PRECISION].
producti  in  PRECISION*SSIZE  lane k imaginary part, same packing.
outaddr  in  BRAM_DEPTH_BITS  grid address the beat accumulates into, all lanes.
clear_start  in  1  request to zero the whole grid.
clear_busy  out  1  high while a clear sweep is pending or running.
rd_req  in  1  readout request.
rd_addr  in  BRAM_DEPTH_BITS  readout address.
rd_valid  out  1  readout data valid.
rd_r  out  PRECISION*SSIZE  accumulated real values at the read address, same packing.
rd_i  out  PRECISION*SSIZE  accumulated imaginary values at the read address, same packing.

Function
REQ-003 Storage SHALL be 2*SSIZE banks (real and imaginary per lane) of 2^BRAM_DEPTH_BITS x PRECISION, synchronous read, one write port each.
REQ-004 The state machine SHALL have states CLEAR, RUN and DRAIN.
REQ-005 CLEAR: a counter SHALL write zero to address 0..2^BRAM_DEPTH_BITS-1 of all banks, one address per cycle, then go to RUN; in_ready=0 and clear_busy=1 throughout.
REQ-006 RUN: in_ready SHALL equal !rd_req; clear_busy=0.
REQ-007 clear_start in RUN SHALL move to DRAIN at that edge, with in_ready=0 from the next cycle.
REQ-008 DRAIN SHALL hold until no accumulate write is pending, then go to CLEAR; clear_busy=1 in DRAIN.
REQ-009 clear_start in CLEAR or DRAIN SHALL be ignored.
REQ-010 Accumulate pipeline:
- Stage 0 (accept edge T): read issued at outaddr; address and products captured into stage 1.
- Stage 1 (edge T+1): per lane, per component, the sum SHALL be written to the bank.
REQ-011 The sum SHALL be old value + product, saturating at +(2^(PRECISION-1)-1) and -2^(PRECISION-1); no wrap-around.
REQ-012 Hazard forwarding: if the beat accepted at T+1 has the same outaddr as the beat accepted at T, its old value SHALL be the sum written at T+1, not the stale RAM data. Back-to-back beats to one address SHALL therefore accumulate exactly.
REQ-013 Throughput SHALL be one beat per cycle with no bubbles when in_ready=1.
REQ-014 Readout: rd_req is honoured only in RUN. It SHALL block acceptance that cycle (REQ-006).
REQ-015 rd_valid SHALL assert for exactly one cycle, one cycle after rd_req.
REQ-016 rd_r/rd_i SHALL equal the committed value, including a stage-1 write to rd_addr that completes on the request edge (forwarded).
REQ-017 rd_req outside RUN SHALL produce no rd_valid.
REQ-018 rd_r/rd_i SHALL hold their last value when rd_valid=0.
REQ-019 At most one write per bank per cycle SHALL occur. Clear writes and accumulate writes never overlap, by REQ-008.

Reset
REQ-020 While rst=1: in_ready=0, clear_busy=1, rd_valid=0, rd_r=0, rd_i=0, pipeline valid flags=0, clear counter=0, state=CLEAR.
REQ-021 Reset mid-accumulation SHALL discard the pending beat. After release, a full CLEAR sweep (1024 cycles at defaults) SHALL precede in_ready=1.
REQ-022 RAM contents are not reset asynchronously; the post-reset CLEAR sweep is the sole initialisation.

Verification
REQ-023 Reset release -> clear_busy=1 for exactly 1024 cycles, then in_ready=1; rd_req at address 0x3FF returns all lanes 0 with rd_valid one cycle later.
REQ-024 Accumulation with hazard:
- Stimulus: three back-to-back beats at outaddr 5, lane k real = k+1, imag = -(k+1).
- Required: readout at address 5 gives real 3(k+1) and imag -3(k+1) for every lane.
REQ-025 Saturation:
- Stimulus: two beats at address 9, lane 0 real = 0x7FFFFFF0 and 0x00000100, lane 0 imag = 0x80000000 twice.
- Required: readout gives lane 0 real 0x7FFFFFFF and imag 0x80000000.
REQ-026 Read/write collision:
- Stimulus: beat to address 12 (value 7) accepted at T; rd_req at address 12 at T+1.
- Required: in_ready=0 at T+1; rd_valid at T+2 with value 7.
REQ-027 Clear during traffic:
- Stimulus: continuous in_valid, clear_start pulsed.
- Required: the last beat is committed; DRAIN lasts at most 1 cycle; 1024 clear cycles follow; every address then reads 0.
REQ-028 Reset during traffic:
- Stimulus: rst pulsed mid-stream.
- Required: outputs take REQ-020 values immediately; after release, the full sweep runs; the previously written address reads 0.

Source files
------------

// File: rtl/grid_accumulator_if.sv
// grid_accumulator_if: product-beat, clear and readout signals of the grid accumulator.
// Ports (slave view): in_valid/productr/producti/outaddr in, in_ready out;
// clear_start in, clear_busy out; rd_req/rd_addr in, rd_valid/rd_r/rd_i out.
interface grid_accumulator_if #(
   parameter int PRECISION       = 32,
   parameter int SSIZE           = 15,
   parameter int BRAM_DEPTH_BITS = 10
);
   logic                         in_valid;
   logic                         in_ready;
   logic [PRECISION*SSIZE-1:0]   productr;
   logic [PRECISION*SSIZE-1:0]   producti;
   logic [BRAM_DEPTH_BITS-1:0]   outaddr;
   logic                         clear_start;
   logic                         clear_busy;
   logic                         rd_req;
   logic [BRAM_DEPTH_BITS-1:0]   rd_addr;
   logic                         rd_valid;
   logic [PRECISION*SSIZE-1:0]   rd_r;
   logic [PRECISION*SSIZE-1:0]   rd_i;
   modport master (
      output in_valid, productr, producti, outaddr, clear_start, rd_req, rd_addr,
      input  in_ready, clear_busy, rd_valid, rd_r, rd_i
   );
   modport slave (
      input  in_valid, productr, producti, outaddr, clear_start, rd_req, rd_addr,
      output in_ready, clear_busy, rd_valid, rd_r, rd_i
   );
endinterface

// File: rtl/grid_accumulator.sv
// grid_accumulator: per-lane complex accumulation of product beats into a banked grid with clear and readout.
// Ports: clk, rst (async, active-high), bus (grid_accumulator_if.slave):
//   in_valid/in_ready/productr/producti/outaddr accept one beat per cycle into stage 1,
//   clear_start/clear_busy run a drain + zeroing sweep, rd_req/rd_addr -> rd_valid/rd_r/rd_i readout.
module grid_accumulator #(
   parameter int PRECISION       = 32,
   parameter int SSIZE           = 15,
   parameter int BRAM_DEPTH_BITS = 10
) (
   input logic                 clk,
   input logic                 rst,
   grid_accumulator_if.slave   bus
);
   localparam int W     = PRECISION*SSIZE;
   localparam int DEPTH = 1 << BRAM_DEPTH_BITS;

   typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

   state_t                     state, state_nx;
   logic [BRAM_DEPTH_BITS-1:0] clr_cnt, s1_addr, raddr, waddr;
   logic [W-1:0]               s1_pr, s1_pi, q_r, q_i, hold_r, hold_i;
   logic                       s1_v, rd_v, fire, clearing, fwd, we;

   function automatic logic [PRECISION-1:0] sat_add(input logic [PRECISION-1:0] a, input logic [PRECISION-1:0] b);
      logic [PRECISION:0] s;
      s = {a[PRECISION-1], a} + {b[PRECISION-1], b};
      return (s[PRECISION] == s[PRECISION-1]) ? s[PRECISION-1:0]
                                              : {s[PRECISION], {(PRECISION-1){~s[PRECISION]}}};
   endfunction

   // DRAIN always lasts one cycle: the only beat that can be pending is the one
   // accepted on the clear_start edge, and it commits on the edge leaving DRAIN.
   always_comb begin
      state_nx = (state == CLEAR) ? ((&clr_cnt) ? RUN : CLEAR)
               : (state == RUN)   ? (bus.clear_start ? DRAIN : RUN)
               : CLEAR;
   end

   assign bus.in_ready   = (state == RUN) && !bus.rd_req;
   assign bus.clear_busy = state != RUN;
   assign bus.rd_valid   = rd_v;
   assign bus.rd_r       = rd_v ? q_r : hold_r;
   assign bus.rd_i       = rd_v ? q_i : hold_i;

   assign fire     = bus.in_valid && bus.in_ready;
   assign clearing = state == CLEAR;
   assign we       = clearing || s1_v;
   assign waddr    = clearing ? clr_cnt : s1_addr;
   // Readout and accumulate share the read port; rd_req blocks acceptance so they never collide.
   assign raddr    = bus.rd_req ? bus.rd_addr : bus.outaddr;
   // The stage-1 write landing on this edge is not yet visible in the RAM read, so bypass it.
   assign fwd      = s1_v && (s1_addr == raddr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         s1_v    <= 1'b0;
         s1_addr <= '0;
         s1_pr   <= '0;
         s1_pi   <= '0;
         rd_v    <= 1'b0;
         hold_r  <= '0;
         hold_i  <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= clearing ? clr_cnt + BRAM_DEPTH_BITS'(1) : '0;
         s1_v    <= fire;
         if (fire) begin
            s1_addr <= bus.outaddr;
            s1_pr   <= bus.productr;
            s1_pi   <= bus.producti;
         end
         rd_v <= bus.rd_req && (state == RUN);
         if (rd_v) begin
            hold_r <= q_r;
            hold_i <= q_i;
         end
      end
   end

   for (genvar k = 0; k < SSIZE; k++) begin : g_lane
      logic [PRECISION-1:0] mem_r [DEPTH];
      logic [PRECISION-1:0] mem_i [DEPTH];
      logic [PRECISION-1:0] sr, si, qr, qi;
      assign sr = sat_add(qr, s1_pr[k*PRECISION +: PRECISION]);
      assign si = sat_add(qi, s1_pi[k*PRECISION +: PRECISION]);
      assign q_r[k*PRECISION +: PRECISION] = qr;
      assign q_i[k*PRECISION +: PRECISION] = qi;
      always_ff @(posedge clk) begin
         if (we) begin
            mem_r[waddr] <= clearing ? '0 : sr;
            mem_i[waddr] <= clearing ? '0 : si;
         end
         qr <= fwd ? sr : mem_r[raddr];
         qi <= fwd ? si : mem_i[raddr];
      end
   end
endmodule
